pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 196 +++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// A parametrised inter-stage pipeline register. It holds one control field
// and one data field per entry and uses a valid/ready handshake backed by a
// 2-entry skid buffer. Because of the skid entry, in_ready is driven from a
// flop and never depends combinationally on out_ready. Backpressure therefore
// moves upstream one stage per cycle.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both 1. A producer holding valid=1 keeps its payload stable
// until that edge. in_ready is registered, so it is already known at the
// start of each cycle.
//
// Parameters:
//   DATA_W  payload width
//   CTRL_W  control-field width; forced to 0 whenever out_valid=0
//   CNT_W   stall-counter width (present only with PIPE_STAGE_PERF_EN)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous flush; discards held entries, highest priority
//   in_valid   upstream entry valid
//   in_ready   stage can accept an entry this cycle (registered)
//   in_ctrl    upstream control field
//   in_data    upstream payload
//   out_valid  entry presented downstream
//   out_ready  downstream accepts the entry
//   out_ctrl   control field, 0 when out_valid=0
//   out_data   payload, holds its last value when invalid
//   occupancy  held entries (0..2); equals the FSM state index
//   stall_cnt  saturating count of out_valid & !out_ready cycles
//              (only when PIPE_STAGE_PERF_EN is defined)
//
// Optional feature macro: PIPE_STAGE_PERF_EN
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // The state encoding is also the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic                r_in_ready;

    logic                w_out_valid;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    // Next-state and datapath load selects
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            // A flush drops everything, including a beat accepted this cycle.
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_next_state   = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_next_state = ST_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_out_fire) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is 0 here, so only the drain case exists.
                    if (w_out_fire) begin
                        w_next_state     = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    // State register and registered in_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
        end
    end

    // Main register. When the stage empties, only the control bits are
    // cleared, so a stored bubble never carries live controls. The data
    // is left in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else if (w_load_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
        end else if (w_load_main_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
        end else if (w_next_state == ST_EMPTY) begin
            r_main_ctrl <= '0;
        end
    end

    // Skid register (second entry)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
        end else if (flush) begin
            r_skid_ctrl <= '0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occupancy = r_state;

`ifdef PIPE_STAGE_PERF_EN
    // Saturating count of cycles in which downstream stalls a valid entry.
    // Only reset clears it.
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Directed bench for pipe_stage_skid. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 4;
`ifdef PIPE_STAGE_PERF_EN
    localparam int CNT_W  = 4;
`endif

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int n_total;
    int n_pass;

    pipe_stage_skid #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0);

        // Reset values
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_occ",       occupancy, 0);
        check("rst_out_ctrl",  out_ctrl,  0);
        check("rst_out_data",  out_data,  0);
        rst = 1'b1;

        // Pass-through
        out_ready = 1'b1;
        drive(1'b1, 64'h1234, 4'h3);
        tick();
        check("pt_out_valid", out_valid, 1);
        check("pt_out_data",  out_data,  64'h1234);
        check("pt_out_ctrl",  out_ctrl,  4'h3);
        check("pt_occ",       occupancy, 1);
        check("pt_in_ready",  in_ready,  1);
        drive(1'b0, '0, '0);
        tick();
        check("pt_drain_occ",  occupancy, 0);
        check("pt_drain_ctrl", out_ctrl,  0);
        check("pt_drain_data", out_data,  64'h1234);

        // Backpressure fill, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 4'h1);
        tick();
        check("bp_a_occ",      occupancy, 1);
        check("bp_a_in_ready", in_ready,  1);
        drive(1'b1, 64'h22, 4'h2);
        tick();
        check("bp_b_occ",      occupancy, 2);
        check("bp_b_in_ready", in_ready,  0);
        check("bp_b_head",     out_data,  64'h11);
        drive(1'b1, 64'h33, 4'h3);
        tick();
        check("bp_c_held_occ",   occupancy, 2);
        check("bp_c_held_ready", in_ready,  0);
        check("bp_c_held_head",  out_data,  64'h11);
        check("bp_c_held_ctrl",  out_ctrl,  4'h1);
        out_ready = 1'b1;
        tick();
        check("bp_out_b_data",  out_data,  64'h22);
        check("bp_out_b_ctrl",  out_ctrl,  4'h2);
        check("bp_out_b_occ",   occupancy, 1);
        check("bp_out_b_ready", in_ready,  1);
        tick();
        check("bp_out_c_data",  out_data,  64'h33);
        check("bp_out_c_ctrl",  out_ctrl,  4'h3);
        check("bp_out_c_valid", out_valid, 1);
        drive(1'b0, '0, '0);
        tick();
        check("bp_empty_occ",   occupancy, 0);
        check("bp_empty_valid", out_valid, 0);

        // Streaming 16 beats at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, DATA_W'(i), CTRL_W'(i));
            tick();
            check("st_valid", out_valid, 1);
            check("st_data",  out_data,  i);
            check("st_ready", in_ready,  1);
        end
        drive(1'b0, '0, '0);
        tick();
        check("st_end_occ", occupancy, 0);

        // Flush from FULL with a beat presented
        out_ready = 1'b0;
        drive(1'b1, 64'hAA, 4'h5);
        tick();
        drive(1'b1, 64'hBB, 4'h6);
        tick();
        check("fl_full_occ", occupancy, 2);
        flush = 1'b1;
        drive(1'b1, 64'hCC, 4'h7);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fl_out_valid", out_valid, 0);
        check("fl_out_ctrl",  out_ctrl,  0);
        check("fl_occ",       occupancy, 0);
        check("fl_in_ready",  in_ready,  1);
        check("fl_data_kept", out_data,  64'hAA);
        out_ready = 1'b1;
        tick();
        check("fl_no_cc_valid", out_valid, 0);
        tick();
        check("fl_no_cc_data",  out_data,  64'hAA);

        // Flush from ONE with an accepted beat in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 64'hDD, 4'h9);
        tick();
        check("fl1_occ_one", occupancy, 1);
        flush = 1'b1;
        drive(1'b1, 64'hEE, 4'hA);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fl1_occ",   occupancy, 0);
        check("fl1_ctrl",  out_ctrl,  0);
        check("fl1_data",  out_data,  64'hDD);

        // Asynchronous reset while FULL and stalled
        drive(1'b1, 64'h55, 4'h1);
        tick();
        drive(1'b1, 64'h66, 4'h2);
        tick();
        drive(1'b0, '0, '0);
        check("ar_full_occ", occupancy, 2);
        #2;
        rst = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_ctrl",  out_ctrl,  0);
        check("ar_out_data",  out_data,  0);
        check("ar_occ",       occupancy, 0);
        check("ar_in_ready",  in_ready,  1);
        tick();
        rst = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter: saturation, survives flush, cleared by reset
        check("pf_rst_cnt", stall_cnt, 0);
        out_ready = 1'b0;
        drive(1'b1, 64'h77, 4'h4);
        tick();
        drive(1'b0, '0, '0);
        check("pf_cnt0", stall_cnt, 0);
        tick();
        check("pf_cnt1", stall_cnt, 1);
        repeat (19) tick();
        check("pf_sat", stall_cnt, 15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("pf_flush_keep", stall_cnt, 15);
        tick();
        check("pf_idle_keep", stall_cnt, 15);
        #2;
        rst = 1'b0;
        #1;
        check("pf_rst_clear", stall_cnt, 0);
        tick();
        rst = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
